// File: rtl/apb_rr_arbiter_if.sv
// apb_rr_arbiter_if: upstream requester and downstream completer APB signals of the arbiter
interface apb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            m_psel_i;
  logic [NUM_MASTERS-1:0]            m_penable_i;
  logic [NUM_MASTERS-1:0]            m_pwrite_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata_i;
  logic [DATA_WIDTH-1:0]             m_prdata_o;
  logic [NUM_MASTERS-1:0]            m_pready_o;
  logic [NUM_MASTERS-1:0]            m_pslverr_o;
  logic                              psel_o;
  logic                              penable_o;
  logic                              pwrite_o;
  logic [ADDR_WIDTH-1:0]             paddr_o;
  logic [DATA_WIDTH-1:0]             pwdata_o;
  logic [DATA_WIDTH-1:0]             prdata_i;
  logic                              pready_i;
  logic                              pslverr_i;
  modport slave (
    input  m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i, prdata_i, pready_i, pslverr_i,
    output m_prdata_o, m_pready_o, m_pslverr_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
  modport master (
    output m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i, prdata_i, pready_i, pslverr_i,
    input  m_prdata_o, m_pready_o, m_pslverr_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of one APB completer between NUM_MASTERS requesters
module apb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  apb_rr_arbiter_if.slave                bus,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
  output logic                           busy_o
);
  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, ptr_q, ptr_d, win, idx;
  logic                  found, timeout, done;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  unused_penable;
  assign unused_penable = &{1'b0, bus.m_penable_i};
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = GW'((int'(ptr_q) + k) % NUM_MASTERS);
      if (!found && bus.m_psel_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d  = SETUP;
        grant_d  = win;
        pwrite_d = bus.m_pwrite_i[win];
        paddr_d  = bus.m_paddr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata_d = bus.m_pwdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (state_q == SETUP) begin
      state_d = ACCESS;
      cnt_d   = '0;
    end else begin
      done  = bus.pready_i || timeout;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        state_d = IDLE;
        ptr_d   = GW'((int'(grant_q) + 1) % NUM_MASTERS);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
    end
  end
  // a timeout abort reports an error even if the completer never drove PSLVERR
  assign bus.m_pready_o  = done ? NUM_MASTERS'(1) << grant_q : '0;
  assign bus.m_pslverr_o = (done && (!bus.pready_i || bus.pslverr_i)) ? NUM_MASTERS'(1) << grant_q : '0;
  assign bus.m_prdata_o  = (state_q == ACCESS && bus.pready_i) ? bus.prdata_i : '0;
  assign bus.psel_o      = state_q != IDLE;
  assign bus.penable_o   = state_q == ACCESS;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign grant_o         = grant_q;
  assign busy_o          = state_q != IDLE;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed scoreboard bench for apb_rr_arbiter
module tb_apb_rr_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  typedef struct {
    int            m;
    logic          err;
    logic [DW-1:0] rdata;
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            acc;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:0]    grant;
  logic          busy;
  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            waits = 0;
  logic [DW-1:0] s_rdata = '0;
  logic          s_err = 1'b0;
  int            acc = 0;
  int            ndone[NM];
  apb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  apb_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .grant_o(grant), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic req(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic err, input logic [DW-1:0] rd, input int ac, input bit push);
    exp_t x;
    bus.m_psel_i[m] = 1'b1;
    bus.m_penable_i[m] = 1'b1;
    bus.m_pwrite_i[m] = w;
    bus.m_paddr_i[m*AW +: AW] = a;
    bus.m_pwdata_i[m*DW +: DW] = d;
    x = '{m, err, rd, w, a, d, ac};
    if (push) sb.push_back(x);
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) return;
    end
    checks++; errors++;
    $display("FAIL %s: still %0d pending after 100 cycles, expected 0", name, sb.size());
  endtask
  task automatic wait_done(input int m, input int n0, input string name);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (ndone[m] != n0) return;
    end
    checks++; errors++;
    $display("FAIL %s: master %0d no pready within 50 cycles, expected one", name, m);
  endtask
  // completer model: drives PREADY after `waits` ACCESS cycles, garbage PRDATA otherwise
  initial begin
    int wc;
    wc = 0;
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    bus.pslverr_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.psel_o && bus.penable_o && wc >= waits) begin
        bus.pready_i = 1'b1;
        bus.prdata_i = s_rdata;
        bus.pslverr_i = s_err;
      end else begin
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'hBAD0_BAD0;
        bus.pslverr_i = 1'b0;
      end
      wc = (bus.psel_o && bus.penable_o) ? wc + 1 : 0;
    end
  end
  initial begin
    for (int i = 0; i < NM; i++) ndone[i] = 0;
    forever begin
      @(negedge clk);
      acc = bus.penable_o ? acc + 1 : 0;
      if (bus.m_pready_o != '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pready: got %b expected 00", bus.m_pready_o);
        end else begin
          e = sb.pop_front();
          chk("pready", bus.m_pready_o, NM'(1) << e.m);
          chk("grant", grant, e.m);
          chk("pslverr", bus.m_pslverr_o, e.err ? NM'(1) << e.m : '0);
          chk("prdata", bus.m_prdata_o, e.rdata);
          chk("pwrite", bus.pwrite_o, e.w);
          chk("paddr", bus.paddr_o, e.addr);
          chk("pwdata", bus.pwdata_o, e.wdata);
          chk("access_cycles", acc, e.acc);
          bus.m_psel_i[e.m] = 1'b0;
          bus.m_penable_i[e.m] = 1'b0;
          ndone[e.m]++;
        end
      end else begin
        chk("prdata_idle", bus.m_prdata_o, 0);
        chk("pslverr_idle", bus.m_pslverr_o, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end
  initial begin
    int n0;
    bus.m_psel_i = '0;
    bus.m_penable_i = '0;
    bus.m_pwrite_i = '0;
    bus.m_paddr_i = '0;
    bus.m_pwdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_pwrite", bus.pwrite_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_m_pready", bus.m_pready_o, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    s_rdata = 32'hA5A5_0000;
    n0 = ndone[0];
    req(0, 1'b1, 32'h0000_0100, 32'h11, 1'b0, 32'hA5A5_0000, 1, 1'b1);
    req(1, 1'b0, 32'h0000_0200, 32'h22, 1'b0, 32'hA5A5_0000, 1, 1'b1);
    wait_done(0, n0, "contention_first");
    req(0, 1'b1, 32'h0000_0300, 32'h33, 1'b0, 32'hA5A5_0000, 1, 1'b1);
    wait_idle("contention");
    s_rdata = '0;
    req(0, 1'b1, 32'h0C00_2000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1'b1);
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    @(negedge clk);
    chk("t1_setup_psel", bus.psel_o, 1);
    chk("t1_setup_penable", bus.penable_o, 0);
    chk("t1_setup_paddr", bus.paddr_o, 32'h0C00_2000);
    chk("t1_setup_pwdata", bus.pwdata_o, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_access_penable", bus.penable_o, 1);
    chk("t1_access_pready", bus.m_pready_o, 2'b01);
    wait_idle("single_write");
    waits = 5;
    s_rdata = 32'h1234_5678;
    req(1, 1'b0, 32'h0C00_0004, 32'h0, 1'b0, 32'h1234_5678, 6, 1'b1);
    wait_idle("wait_read");
    waits = 1000;
    n0 = ndone[0];
    req(0, 1'b0, 32'h0C00_0008, 32'h0, 1'b1, 32'h0, TO, 1'b1);
    wait_done(0, n0, "timeout");
    @(negedge clk);
    chk("timeout_psel_drop", bus.psel_o, 0);
    wait_idle("timeout");
    waits = 1;
    s_err = 1'b1;
    s_rdata = 32'h55;
    req(0, 1'b1, 32'h0C00_000C, 32'hCAFE, 1'b1, 32'h55, 2, 1'b1);
    wait_idle("slverr");
    s_err = 1'b0;
    waits = 1000;
    req(1, 1'b0, 32'h0C00_0010, 32'h0, 1'b0, 32'h0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("t6_in_access", bus.penable_o, 1);
    rst = 1'b1;
    bus.m_psel_i = '0;
    bus.m_penable_i = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_psel", bus.psel_o, 0);
    chk("t6_penable", bus.penable_o, 0);
    chk("t6_paddr", bus.paddr_o, 0);
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_m_pready", bus.m_pready_o, 0);
    @(posedge clk); #2;
    waits = 0;
    s_rdata = 32'h77;
    req(0, 1'b1, 32'h0C00_0014, 32'hA0, 1'b0, 32'h77, 1, 1'b1);
    req(1, 1'b1, 32'h0C00_0018, 32'hB1, 1'b0, 32'h77, 1, 1'b1);
    wait_idle("after_reset");
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
